// File: rtl/dev_intc.sv
// dev_intc: memory-mapped interrupt controller for the CPU I/O bus.
//
// Rising edges on the device event lines are latched into pending bits. The
// pending bits are gated by an enable mask. The lowest-numbered active source
// is offered to the CPU through a single registered IRQ line. Only one
// interrupt is in service at a time: a claim read takes it, and an EOI write
// that echoes the claimed ID releases it.
//
// Ports:
//   CLK       system clock; all state changes on the rising edge
//   RESET     asynchronous, active-high reset
//   ABUS      bus address (each access is held for exactly one cycle)
//   DBUS_IN   write data
//   DBUS_OUT  combinational read data; zero unless a read hits a register
//   WE        1 = write, 0 = read
//   IRQ_SRC   device event lines, synchronous to CLK (bit 0 = timer)
//   IRQ       registered interrupt request to the CPU
module dev_intc #(
  parameter int               DBITS     = 32,
  parameter int               NSRC      = 4,
  parameter logic [DBITS-1:0] PENDADDR  = 32'hF0000100,
  parameter logic [DBITS-1:0] ENADDR    = 32'hF0000104,
  parameter logic [DBITS-1:0] CLAIMADDR = 32'hF0000108,
  parameter logic [DBITS-1:0] EOIADDR   = 32'hF000010C
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ABUS,
  input  logic [DBITS-1:0] DBUS_IN,
  output logic [DBITS-1:0] DBUS_OUT,
  input  logic             WE,
  input  logic [NSRC-1:0]  IRQ_SRC,
  output logic             IRQ
);

  // ID 0 means "no source", so IDs need room for the values 0..NSRC.
  localparam int IDW = $clog2(NSRC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_INSVC
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] prev_q;
  logic [IDW-1:0]  insvc_q, insvc_d;
  logic            irq_q;

  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] sel_onehot;
  logic [IDW-1:0]  sel_id;
  logic            claim_rd, pend_wr, en_wr, eoi_wr;
  logic            claim_take;
  logic [NSRC-1:0] clr_mask;

  // Bus decode.
  assign claim_rd = !WE && (ABUS == CLAIMADDR);
  assign pend_wr  =  WE && (ABUS == PENDADDR);
  assign en_wr    =  WE && (ABUS == ENADDR);
  assign eoi_wr   =  WE && (ABUS == EOIADDR);

  // prev_q resets to 0, so a line already high when reset is released
  // still produces exactly one event.
  assign src_edge = IRQ_SRC & ~prev_q;
  assign active   = pend_q & en_q;

  // Lowest index wins. The loop runs downwards so the last hit is the lowest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    sel_onehot = '0;
    sel_id     = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_id        = IDW'(i + 1);
      end
    end
  end

  // Claim/EOI handshake.
  always_comb begin
    state_d    = state_q;
    insvc_d    = insvc_q;
    claim_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|active) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (claim_rd) begin
          if (|active) begin
            claim_take = 1'b1;
            insvc_d    = sel_id;
            state_d    = ST_INSVC;
          end else begin
            // The source was withdrawn under us: this claim returns 0.
            state_d = ST_IDLE;
          end
        end else if (!(|active)) begin
          state_d = ST_IDLE;
        end
      end
      ST_INSVC: begin
        // Only an EOI that echoes the in-service ID releases it.
        if (eoi_wr && (DBUS_IN == DBITS'(insvc_q))) begin
          insvc_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clears are applied before the edge OR, so a new edge wins over a
  // clear that lands in the same cycle.
  assign clr_mask = (pend_wr    ? DBUS_IN[NSRC-1:0] : '0)
                  | (claim_take ? sel_onehot        : '0);
  assign pend_d   = (pend_q & ~clr_mask) | src_edge;
  assign en_d     = en_wr ? DBUS_IN[NSRC-1:0] : en_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      en_q    <= '0;
      prev_q  <= '0;
      insvc_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      prev_q  <= IRQ_SRC;
      insvc_q <= insvc_d;
      // Register the next state so that IRQ mirrors ARMED on the same cycle.
      irq_q   <= (state_d == ST_ARMED);
    end
  end

  assign IRQ = irq_q;

  // Read mux. Register values are zero-extended.
  always_comb begin
    DBUS_OUT = '0;
    if (!WE) begin
      if (ABUS == PENDADDR) begin
        DBUS_OUT[NSRC-1:0] = pend_q;
      end else if (ABUS == ENADDR) begin
        DBUS_OUT[NSRC-1:0] = en_q;
      end else if (ABUS == CLAIMADDR) begin
        if (state_q == ST_ARMED) DBUS_OUT[IDW-1:0] = sel_id;
      end else if (ABUS == EOIADDR) begin
        DBUS_OUT[IDW-1:0] = insvc_q;
      end
    end
  end

endmodule

// File: tb/tb_dev_intc.sv
// tb_dev_intc: self-checking bench for dev_intc (default parameters).
// A behavioural model tracks the pending, enable and in-service state. On
// every falling edge, a compare process checks IRQ and DBUS_OUT against that
// model. Directed stimulus adds literal expectations at key points.
module tb_dev_intc;

  localparam logic [31:0] PENDADDR  = 32'hF0000100;
  localparam logic [31:0] ENADDR    = 32'hF0000104;
  localparam logic [31:0] CLAIMADDR = 32'hF0000108;
  localparam logic [31:0] EOIADDR   = 32'hF000010C;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ABUS = '0;
  logic [31:0] DBUS_IN = '0;
  logic [31:0] DBUS_OUT;
  logic        WE = 1'b0;
  logic [3:0]  IRQ_SRC = '0;
  logic        IRQ;

  int checks = 0;
  int failures = 0;

  dev_intc dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ABUS     (ABUS),
    .DBUS_IN  (DBUS_IN),
    .DBUS_OUT (DBUS_OUT),
    .WE       (WE),
    .IRQ_SRC  (IRQ_SRC),
    .IRQ      (IRQ)
  );

  always #10 CLK = ~CLK;

  // Reference model state.
  typedef struct packed {
    logic [3:0]  pend;
    logic [3:0]  en;
    logic [3:0]  prev;
    logic        armed;   // IRQ offered, waiting for a claim
    logic [31:0] insvc;   // claimed ID, 0 when nothing is in service
  } mstate_t;

  mstate_t m = '0;

  function automatic logic [31:0] lowest_id(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic we,
                                         input logic [31:0] addr,
                                         input logic [31:0] din,
                                         input logic [3:0] src);
    mstate_t     n;
    logic [3:0]  act;
    logic [3:0]  clr;
    logic [31:0] id;
    n   = s;
    act = s.pend & s.en;
    id  = lowest_id(act);
    clr = '0;
    if (s.insvc != 0) begin
      if (we && addr == EOIADDR && din == s.insvc) n.insvc = 0;
    end else if (!s.armed) begin
      if (act != 0) n.armed = 1'b1;
    end else if (!we && addr == CLAIMADDR) begin
      n.armed = 1'b0;
      if (id != 0) begin
        clr[id - 1] = 1'b1;
        n.insvc     = id;
      end
    end else if (act == 0) begin
      n.armed = 1'b0;
    end
    if (we && addr == PENDADDR) clr = clr | din[3:0];
    if (we && addr == ENADDR) n.en = din[3:0];
    n.pend = (s.pend & ~clr) | (src & ~s.prev);
    n.prev = src;
    return n;
  endfunction

  function automatic logic [31:0] model_dout(input mstate_t s, input logic we,
                                             input logic [31:0] addr);
    if (we) return 32'd0;
    case (addr)
      PENDADDR:  return {28'd0, s.pend};
      ENADDR:    return {28'd0, s.en};
      CLAIMADDR: return s.armed ? lowest_id(s.pend & s.en) : 32'd0;
      EOIADDR:   return s.insvc;
      default:   return 32'd0;
    endcase
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) m <= '0;
    else       m <= model_next(m, WE, ABUS, DBUS_IN, IRQ_SRC);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    if (!RESET) begin
      check("model_irq", {31'd0, IRQ}, {31'd0, m.armed});
      check("model_dout", DBUS_OUT, model_dout(m, WE, ABUS));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    ABUS = addr; WE = 1'b1; DBUS_IN = d;
    tick();
    ABUS = '0; WE = 1'b0; DBUS_IN = '0;
  endtask

  task automatic peek(input logic [31:0] addr, input logic [31:0] exp,
                      input string name);
    ABUS = addr; WE = 1'b0;
    #1;
    check(name, DBUS_OUT, exp);
    ABUS = '0;
  endtask

  task automatic claim(input logic [31:0] exp, input string name);
    ABUS = CLAIMADDR; WE = 1'b0;
    #1;
    check(name, DBUS_OUT, exp);
    tick();
    ABUS = '0;
  endtask

  task automatic pulse(input logic [3:0] s);
    IRQ_SRC = s;
    tick();
    IRQ_SRC = '0;
  endtask

  task automatic chk_irq(input logic exp, input string name);
    check(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk_irq(1'b0, "reset_irq");
    peek(PENDADDR, 32'd0, "reset_pend");
    peek(EOIADDR, 32'd0, "reset_eoi");
    @(negedge CLK);
    RESET = 1'b0;
    tick();

    // Single timer pulse, full claim/EOI handshake.
    wr(ENADDR, 32'h1);
    pulse(4'b0001);
    chk_irq(1'b0, "t1_irq_edge+1");
    peek(PENDADDR, 32'h1, "t1_pend_set");
    tick();
    chk_irq(1'b1, "t1_irq_edge+2");
    claim(32'd1, "t1_claim");
    chk_irq(1'b0, "t1_irq_after_claim");
    peek(PENDADDR, 32'h0, "t1_pend_cleared");
    peek(EOIADDR, 32'd1, "t1_insvc");
    wr(EOIADDR, 32'd1);
    chk_irq(1'b0, "t1_irq_after_eoi");
    tick();
    chk_irq(1'b0, "t1_irq_stays_low");
    peek(EOIADDR, 32'd0, "t1_insvc_cleared");

    // Two simultaneous sources: lowest first, then re-arm after EOI.
    wr(ENADDR, 32'hF);
    pulse(4'b1010);
    tick();
    chk_irq(1'b1, "t2_irq");
    claim(32'd2, "t2_claim_first");
    chk_irq(1'b0, "t2_irq_insvc");
    wr(EOIADDR, 32'd2);
    chk_irq(1'b0, "t2_irq_eoi+1");
    tick();
    chk_irq(1'b1, "t2_irq_eoi+2");
    claim(32'd4, "t2_claim_second");
    wr(EOIADDR, 32'd4);
    chk_irq(1'b0, "t2_irq_done");
    peek(PENDADDR, 32'h0, "t2_pend_done");

    // Long level on a disabled source, then enable and W1C.
    wr(ENADDR, 32'h0);
    IRQ_SRC = 4'b0100;
    repeat (10) tick();
    IRQ_SRC = '0;
    peek(PENDADDR, 32'h4, "t3_pend_one_event");
    chk_irq(1'b0, "t3_irq_disabled");
    wr(ENADDR, 32'h4);
    chk_irq(1'b0, "t3_irq_en+1");
    tick();
    chk_irq(1'b1, "t3_irq_en+2");
    wr(PENDADDR, 32'h4);
    tick();
    chk_irq(1'b0, "t3_irq_after_w1c");

    // Wrong-ID EOI ignored; edges during service wait for the EOI.
    wr(ENADDR, 32'h1);
    pulse(4'b0001);
    tick();
    claim(32'd1, "t4_claim");
    wr(EOIADDR, 32'd3);
    chk_irq(1'b0, "t4_irq_bad_eoi");
    peek(EOIADDR, 32'd1, "t4_insvc_kept");
    pulse(4'b0001);
    tick();
    chk_irq(1'b0, "t4_irq_held_off");
    peek(PENDADDR, 32'h1, "t4_pend_during_insvc");
    wr(EOIADDR, 32'd1);
    chk_irq(1'b0, "t4_irq_eoi+1");
    tick();
    chk_irq(1'b1, "t4_irq_eoi+2");
    claim(32'd1, "t4_claim_again");
    wr(EOIADDR, 32'd1);

    // A new edge wins over a W1C in the same cycle; claim while idle has no effect.
    wr(ENADDR, 32'h0);
    IRQ_SRC = 4'b0001;
    wr(PENDADDR, 32'h1);
    IRQ_SRC = '0;
    peek(PENDADDR, 32'h1, "t5_set_beats_clear");
    claim(32'd0, "t5_claim_idle");
    peek(PENDADDR, 32'h1, "t5_pend_unchanged");
    chk_irq(1'b0, "t5_irq");

    // Asynchronous reset mid-handshake.
    wr(ENADDR, 32'hF);
    tick();
    claim(32'd1, "t6_claim");
    pulse(4'b1010);
    tick();
    peek(PENDADDR, 32'hA, "t6_pend_before_reset");
    peek(EOIADDR, 32'd1, "t6_insvc_before_reset");
    #2;
    RESET = 1'b1;
    #1;
    chk_irq(1'b0, "t6_irq_async");
    peek(PENDADDR, 32'h0, "t6_pend_async");
    peek(ENADDR, 32'h0, "t6_en_async");
    peek(EOIADDR, 32'd0, "t6_eoi_async");

    // A line high through reset release gives exactly one event.
    IRQ_SRC = 4'b0010;
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    peek(PENDADDR, 32'h2, "t7_edge_at_release");
    wr(PENDADDR, 32'h2);
    repeat (3) tick();
    peek(PENDADDR, 32'h0, "t7_held_no_reedge");
    chk_irq(1'b0, "t7_irq");
    IRQ_SRC = '0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
